// File: rtl/sargantana_icache_pkg.sv
// Shared types for the icache fill path: fill-port owner and arbiter FSM state.
package sargantana_icache_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DMD  = 2'd1,
        OWN_PF   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/sargantana_icache_ifill_arbiter_chk.sv
// Protocol checker for the fill arbiter: flags L2 fills arriving with nothing outstanding.
module sargantana_icache_ifill_arbiter_chk
    import sargantana_icache_pkg::*;
(
    input  logic   clk_i,
    input  logic   rstn_i,
    input  state_e state_i,
    input  logic   fill_i
);

    // A fill is only legal while a request is in flight (WAIT) or being drained.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            assert (!(fill_i && ((state_i == ST_IDLE) || (state_i == ST_REQ))))
            else $warning("ifill arbiter: fill response with no outstanding request, ignored");
        end
    end

endmodule

// File: rtl/sargantana_icache_ifill_arbiter.sv
// Single-port L2 instruction-fill arbiter: demand misses over next-line prefetches,
// one fill outstanding, demand-onto-prefetch merging and kill draining.
module sargantana_icache_ifill_arbiter
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned PADDR_W = 40,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned WAY_W   = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               dmd_req_valid_i,
    input  logic [PADDR_W-1:0] dmd_req_paddr_i,
    input  logic [WAY_W-1:0]   dmd_req_way_i,
    input  logic               dmd_kill_i,
    output logic               dmd_ack_o,
    input  logic               pf_req_valid_i,
    input  logic [PADDR_W-1:0] pf_req_paddr_i,
    output logic               pf_req_ready_o,
    output logic               l2_req_valid_o,
    input  logic               l2_req_ready_i,
    output logic [PADDR_W-1:0] l2_req_paddr_o,
    output logic [WAY_W-1:0]   l2_req_way_o,
    input  logic               l2_resp_valid_i,
    input  logic               l2_resp_inv_i,
    input  logic [LINE_W-1:0]  l2_resp_data_i,
    output logic               dmd_resp_valid_o,
    output logic               pf_resp_valid_o,
    output logic [LINE_W-1:0]  resp_data_o,
    output logic               inv_valid_o,
    output logic               busy_o
);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [PADDR_W-1:0] paddr_q, paddr_d;
    logic [WAY_W-1:0]   way_q, way_d;

    logic dmd_go_s;
    logic fill_s;
    logic merge_s;
    logic pf_owned_s;
    logic dmd_owned_s;

    assign dmd_go_s    = dmd_req_valid_i & ~dmd_kill_i;
    assign fill_s      = l2_resp_valid_i & ~l2_resp_inv_i;
    assign pf_owned_s  = (owner_q == OWN_PF);
    assign dmd_owned_s = (owner_q == OWN_DMD);
    // A demand can only ride an in-flight prefetch when it wants exactly that line.
    assign merge_s     = pf_owned_s & dmd_go_s & (dmd_req_paddr_i == paddr_q);

    // State, owner and captured request registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            paddr_q <= {PADDR_W{1'b0}};
            way_q   <= {WAY_W{1'b0}};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            paddr_q <= paddr_d;
            way_q   <= way_d;
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        paddr_d = paddr_q;
        way_d   = way_q;
        case (state_q)
            ST_IDLE: begin
                if (dmd_go_s) begin
                    state_d = ST_REQ;
                    owner_d = OWN_DMD;
                    paddr_d = dmd_req_paddr_i;
                    way_d   = dmd_req_way_i;
                end else if (pf_req_valid_i) begin
                    state_d = ST_REQ;
                    owner_d = OWN_PF;
                    paddr_d = pf_req_paddr_i;
                    way_d   = {WAY_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmd_owned_s && dmd_kill_i) begin
                    // Once L2 has taken the request its fill must still be absorbed.
                    state_d = l2_req_ready_i ? ST_DRAIN : ST_IDLE;
                    owner_d = OWN_NONE;
                end else if (l2_req_ready_i) begin
                    state_d = ST_WAIT;
                end else if (pf_owned_s && dmd_go_s) begin
                    owner_d = OWN_DMD;
                    paddr_d = dmd_req_paddr_i;
                    way_d   = dmd_req_way_i;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (fill_s) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end else if (dmd_owned_s && dmd_kill_i) begin
                    state_d = ST_DRAIN;
                    owner_d = OWN_NONE;
                end else if (merge_s) begin
                    owner_d = OWN_DMD;
                    way_d   = dmd_req_way_i;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (fill_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Handshake and response steering outputs.
    always_comb begin
        dmd_ack_o        = 1'b0;
        pf_req_ready_o   = 1'b0;
        l2_req_valid_o   = 1'b0;
        dmd_resp_valid_o = 1'b0;
        pf_resp_valid_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dmd_ack_o      = dmd_go_s;
                pf_req_ready_o = ~dmd_go_s & pf_req_valid_i;
            end
            ST_REQ: begin
                l2_req_valid_o = 1'b1;
                dmd_ack_o      = pf_owned_s & dmd_go_s & ~l2_req_ready_i;
            end
            ST_WAIT: begin
                dmd_ack_o = merge_s;
                if (fill_s) begin
                    // A merge landing on the fill cycle hands the line to the demand.
                    dmd_resp_valid_o = dmd_owned_s | merge_s;
                    pf_resp_valid_o  = pf_owned_s & ~merge_s;
                end else begin
                    dmd_resp_valid_o = 1'b0;
                    pf_resp_valid_o  = 1'b0;
                end
            end
            ST_DRAIN: begin
                dmd_ack_o = 1'b0;
            end
            default: begin
                dmd_ack_o = 1'b0;
            end
        endcase
    end

    assign l2_req_paddr_o = paddr_q;
    assign l2_req_way_o   = way_q;
    assign resp_data_o    = l2_resp_data_i;
    assign inv_valid_o    = l2_resp_valid_i & l2_resp_inv_i;
    assign busy_o         = (state_q != ST_IDLE);

    sargantana_icache_ifill_arbiter_chk u_chk (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .state_i (state_q),
        .fill_i  (fill_s)
    );

endmodule

// File: tb/tb_sargantana_icache_ifill_arbiter.sv
// Directed, table-driven bench for the icache fill arbiter plus a reset-in-flight sequence.
module tb_sargantana_icache_ifill_arbiter;

    localparam int unsigned PADDR_W = 40;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned WAY_W   = 2;

    localparam logic [39:0] A = 40'h0080001000;
    localparam logic [39:0] B = 40'h0080001020;
    localparam logic [39:0] C = 40'h0080002000;
    localparam logic [39:0] Z = 40'h0000000000;

    logic               clk;
    logic               rstn;
    logic               dmd_req_valid;
    logic [PADDR_W-1:0] dmd_req_paddr;
    logic [WAY_W-1:0]   dmd_req_way;
    logic               dmd_kill;
    logic               dmd_ack;
    logic               pf_req_valid;
    logic [PADDR_W-1:0] pf_req_paddr;
    logic               pf_req_ready;
    logic               l2_req_valid;
    logic               l2_req_ready;
    logic [PADDR_W-1:0] l2_req_paddr;
    logic [WAY_W-1:0]   l2_req_way;
    logic               l2_resp_valid;
    logic               l2_resp_inv;
    logic [LINE_W-1:0]  l2_resp_data;
    logic               dmd_resp_valid;
    logic               pf_resp_valid;
    logic [LINE_W-1:0]  resp_data;
    logic               inv_valid;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;

    sargantana_icache_ifill_arbiter #(
        .PADDR_W (PADDR_W),
        .LINE_W  (LINE_W),
        .WAY_W   (WAY_W)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .dmd_req_valid_i  (dmd_req_valid),
        .dmd_req_paddr_i  (dmd_req_paddr),
        .dmd_req_way_i    (dmd_req_way),
        .dmd_kill_i       (dmd_kill),
        .dmd_ack_o        (dmd_ack),
        .pf_req_valid_i   (pf_req_valid),
        .pf_req_paddr_i   (pf_req_paddr),
        .pf_req_ready_o   (pf_req_ready),
        .l2_req_valid_o   (l2_req_valid),
        .l2_req_ready_i   (l2_req_ready),
        .l2_req_paddr_o   (l2_req_paddr),
        .l2_req_way_o     (l2_req_way),
        .l2_resp_valid_i  (l2_resp_valid),
        .l2_resp_inv_i    (l2_resp_inv),
        .l2_resp_data_i   (l2_resp_data),
        .dmd_resp_valid_o (dmd_resp_valid),
        .pf_resp_valid_o  (pf_resp_valid),
        .resp_data_o      (resp_data),
        .inv_valid_o      (inv_valid),
        .busy_o           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle of stimulus and its expected outputs.
    // ctrl bit order: {dmd_ack, pf_ready, l2_req_valid, dmd_resp, pf_resp, inv_valid, busy}
    typedef struct {
        logic        dv;
        logic [39:0] dpa;
        logic [1:0]  dw;
        logic        kill;
        logic        pv;
        logic [39:0] ppa;
        logic        rdy;
        logic        rv;
        logic        ri;
        logic [6:0]  ctrl;
        logic [39:0] epa;
        logic [1:0]  ew;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic dv, input logic [39:0] dpa, input logic [1:0] dw,
                                input logic kill, input logic pv, input logic [39:0] ppa,
                                input logic rdy, input logic rv, input logic ri,
                                input logic [6:0] ctrl, input logic [39:0] epa, input logic [1:0] ew);
        vec_t v;
        v.dv = dv; v.dpa = dpa; v.dw = dw; v.kill = kill; v.pv = pv; v.ppa = ppa;
        v.rdy = rdy; v.rv = rv; v.ri = ri; v.ctrl = ctrl; v.epa = epa; v.ew = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic drive_idle();
        dmd_req_valid = 1'b0; dmd_req_paddr = Z; dmd_req_way = 2'd0; dmd_kill = 1'b0;
        pf_req_valid = 1'b0; pf_req_paddr = Z; l2_req_ready = 1'b0;
        l2_resp_valid = 1'b0; l2_resp_inv = 1'b0; l2_resp_data = {LINE_W{1'b0}};
    endtask

    function automatic logic [6:0] ctrl_now();
        return {dmd_ack, pf_req_ready, l2_req_valid, dmd_resp_valid, pf_resp_valid, inv_valid, busy};
    endfunction

    initial begin
        // Single demand, then demand vs prefetch priority.
        vecs.push_back(mk(1'b1, A, 2'd2, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b1000000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, A, 2'd2));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b0001001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000000, Z, 2'd0));
        vecs.push_back(mk(1'b1, A, 2'd1, 1'b0, 1'b1, B, 1'b0, 1'b0, 1'b0, 7'b1000000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b1, B, 1'b1, 1'b0, 1'b0, 7'b0010001, A, 2'd1));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b1, B, 1'b0, 1'b1, 1'b0, 7'b0001001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b1, B, 1'b0, 1'b0, 1'b0, 7'b0100000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, B, 2'd0));
        // Demand merges onto the outstanding prefetch of the same line.
        vecs.push_back(mk(1'b1, B, 2'd3, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b1000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b0001001, Z, 2'd0));
        // Kill in WAIT drains the fill silently.
        vecs.push_back(mk(1'b1, A, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b1000000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, A, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b1, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b1, C, 2'd1, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b1000000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, C, 2'd1));
        // Invalidation in WAIT passes through, then the real fill completes.
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b1, 7'b0000011, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b0001001, Z, 2'd0));
        // Kill in REQ: without L2 ready back to IDLE, with L2 ready into DRAIN.
        vecs.push_back(mk(1'b1, A, 2'd2, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b1000000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b1, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0010001, A, 2'd2));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000000, Z, 2'd0));
        vecs.push_back(mk(1'b1, C, 2'd3, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b1000000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b1, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, C, 2'd3));
        vecs.push_back(mk(1'b1, A, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b1, A, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b1, A, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b1000000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, A, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b0001001, Z, 2'd0));
        // Unissued prefetch replaced by a demand in REQ.
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b1, B, 1'b0, 1'b0, 1'b0, 7'b0100000, Z, 2'd0));
        vecs.push_back(mk(1'b1, C, 2'd2, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b1010001, B, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, C, 2'd2));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b0001001, Z, 2'd0));
        // Different-line demand waits; same-line merge coinciding with the fill goes to demand.
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b1, B, 1'b0, 1'b0, 1'b0, 7'b0100000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, B, 2'd0));
        vecs.push_back(mk(1'b1, A, 2'd1, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b1, B, 2'd1, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b1001001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000000, Z, 2'd0));
        // Kill is ignored while a prefetch owns the port.
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b1, B, 1'b0, 1'b0, 1'b0, 7'b0100000, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b1, 1'b0, Z, 1'b1, 1'b0, 1'b0, 7'b0010001, B, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b1, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000001, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b1, 1'b0, 7'b0000101, Z, 2'd0));
        vecs.push_back(mk(1'b0, Z, 2'd0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, 7'b0000000, Z, 2'd0));

        rstn = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #2;
        check("reset_ctrl", 64'(ctrl_now()), 64'd0);
        check("reset_addr", 64'({l2_req_paddr, l2_req_way}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            dmd_req_valid = vecs[i].dv;  dmd_req_paddr = vecs[i].dpa; dmd_req_way = vecs[i].dw;
            dmd_kill      = vecs[i].kill; pf_req_valid = vecs[i].pv;  pf_req_paddr = vecs[i].ppa;
            l2_req_ready  = vecs[i].rdy; l2_resp_valid = vecs[i].rv;  l2_resp_inv = vecs[i].ri;
            l2_resp_data  = {8{32'(i) ^ 32'hA5A5_0000}};
            #2;
            check($sformatf("row%0d_ctrl", i), 64'(ctrl_now()), 64'(vecs[i].ctrl));
            if (vecs[i].ctrl[4]) begin
                check($sformatf("row%0d_l2addr", i), 64'({l2_req_paddr, l2_req_way}),
                      64'({vecs[i].epa, vecs[i].ew}));
            end
            if (vecs[i].rv) begin
                check($sformatf("row%0d_data", i), 64'(resp_data[63:0]),
                      64'({2{32'(i) ^ 32'hA5A5_0000}}));
            end
        end

        // Reset while a demand fill is outstanding, then a stray fill after release.
        @(negedge clk);
        drive_idle();
        dmd_req_valid = 1'b1; dmd_req_paddr = C; dmd_req_way = 2'd3;
        @(negedge clk);
        drive_idle();
        l2_req_ready = 1'b1;
        @(negedge clk);
        drive_idle();
        #2;
        check("wait_busy", 64'(ctrl_now()), 64'(7'b0000001));
        rstn = 1'b0;
        #1;
        check("async_rst_ctrl", 64'(ctrl_now()), 64'd0);
        check("async_rst_addr", 64'({l2_req_paddr, l2_req_way}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        l2_resp_valid = 1'b1;
        #2;
        check("stray_fill", 64'(ctrl_now()), 64'd0);
        @(negedge clk);
        drive_idle();
        dmd_req_valid = 1'b1; dmd_req_paddr = A; dmd_req_way = 2'd1;
        #2;
        check("post_rst_ack", 64'(ctrl_now()), 64'(7'b1000000));
        @(negedge clk);
        drive_idle();
        #2;
        check("post_rst_req", 64'({l2_req_valid, l2_req_paddr, l2_req_way}), 64'({1'b1, A, 2'd1}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_ifill_arbiter.md
Name: sargantana_icache_ifill_arbiter

Overview:
Arbitrates the single L2 instruction-fill port between demand misses from the icache controller and next-line prefetch requests. Sits between the icache top level and the upper memory levels. Holds at most one outstanding fill and steers each returning line to its owner. A demand whose line is already in flight as a prefetch is merged onto it instead of being re-issued. Kills and L2 invalidations are handled without losing the port.

Parameters:
PADDR_W, 40, physical address width; line-aligned, low 5 bits are zero.
LINE_W, 256, cache-line data width in bits.
WAY_W, 2, width of the way-to-replace field.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
dmd_req_valid_i  in  1  demand fill request; level signal, held until accepted
dmd_req_paddr_i  in  PADDR_W  demand line address
dmd_req_way_i  in  WAY_W  victim way for the demand fill
dmd_kill_i  in  1  core kill of the current demand
dmd_ack_o  out  1  demand accepted (issued or merged)
pf_req_valid_i  in  1  prefetch request
pf_req_paddr_i  in  PADDR_W  prefetch line address
pf_req_ready_o  out  1  prefetch accepted this cycle
l2_req_valid_o  out  1  request to L2
l2_req_ready_i  in  1  L2 accepts request
l2_req_paddr_o  out  PADDR_W  address to L2
l2_req_way_o  out  WAY_W  way field forwarded to L2
l2_resp_valid_i  in  1  L2 response valid
l2_resp_inv_i  in  1  response is an invalidation, not a fill
l2_resp_data_i  in  LINE_W  fill data
dmd_resp_valid_o  out  1  fill completes the demand; write the icache
pf_resp_valid_o  out  1  fill completes a prefetch; goes to the prefetch buffer
resp_data_o  out  LINE_W  registered-free passthrough of l2_resp_data_i
inv_valid_o  out  1  invalidation passthrough; asserted as l2_resp_valid_i & l2_resp_inv_i
busy_o  out  1  state is not IDLE

Behaviour:
- Reset: state IDLE. The following outputs are 0: owner, paddr/way registers, dmd_ack_o, pf_req_ready_o, l2_req_valid_o, dmd_resp_valid_o, pf_resp_valid_o, busy_o.
- Owner register, 2 bits, one of NONE, DMD, PF. Address and way registers are captured on grant.
- IDLE:
  - dmd_req_valid_i & ~dmd_kill_i: grant demand, assert dmd_ack_o for 1 cycle, go to REQ.
  - Otherwise, if pf_req_valid_i: grant prefetch, assert pf_req_ready_o for 1 cycle (combinational with grant), go to REQ.
  - Demand has strict priority.
- REQ:
  - l2_req_valid_o=1 with address and way taken from the registers.
  - l2_req_ready_i: go to WAIT.
  - Owner PF and a demand arrives: the prefetch is replaced by the demand. Same cycle the demand is captured, dmd_ack_o pulses, and the state stays in REQ, since the prefetch has not yet been issued.
- WAIT:
  - l2_resp_valid_i & ~l2_resp_inv_i: complete. Owner DMD pulses dmd_resp_valid_o; owner PF pulses pf_resp_valid_o. Go to IDLE.
  - Merge: owner PF and dmd_req_valid_i with dmd_req_paddr_i == the registered paddr. Owner becomes DMD, dmd_ack_o pulses, and the demand way is captured.
  - A demand to a different address is not acked; it waits for IDLE.
- DRAIN:
  - Entered from WAIT when dmd_kill_i is seen with owner DMD.
  - Waits for the fill; the fill is consumed with both resp valids held at 0; then goes to IDLE.
  - No new request is issued while in DRAIN.
- Kill in REQ with owner DMD: drop the request before issue, return to IDLE; l2_req_valid_o deasserts next cycle. If l2_req_ready_i is high in the same cycle, go to DRAIN instead.
- Kill is ignored for owner PF.
- Invalidation responses never change state; inv_valid_o passes combinationally.
- A fill response and a merge in the same cycle: the response is credited to DMD (dmd_resp_valid_o=1).
- A fill while IDLE or REQ is a protocol error: ignored, with an assertion flagged.

Decomposition:
- Package sargantana_icache_pkg gets the owner enum (NONE/DMD/PF) and the state enum (IDLE/REQ/WAIT/DRAIN).
- No sub-module; single FSM plus capture registers.

Test Plan:
- Demand alone, paddr 0x80001000, way 2, L2 ready at cycle 1, fill at cycle 5 -> l2_req_paddr_o=0x80001000, way 2; dmd_resp_valid_o=1 exactly at cycle 5; busy_o=0 at cycle 6.
- Demand and prefetch both valid in IDLE -> demand granted; pf_req_ready_o=0; prefetch is issued after the demand fill completes.
- Prefetch 0x80001020 outstanding in WAIT, demand to 0x80001020 -> dmd_ack_o without a second L2 request; fill raises dmd_resp_valid_o and pf_resp_valid_o stays 0.
- Demand in WAIT killed at cycle 3, fill at cycle 6 -> state DRAIN; no resp valid at cycle 6; IDLE at cycle 7; new demand is issued afterwards.
- Invalidation (l2_resp_valid_i=1, l2_resp_inv_i=1) during WAIT -> inv_valid_o=1, state unchanged, later real fill completes normally.
- Reset asserted during WAIT -> all outputs 0 immediately; a stray fill after release produces no resp valid.
